// File: rtl/chip_6502_run_ctrl.sv
// Run controller and memory-port arbiter: host loader/debug port vs 6502 bus, LOAD/RESET_HOLD/RUN/HALT sequencing.
// Host access acks one cycle after accept; host requests stall while the CPU owns memory.
module chip_6502_run_ctrl #(
  parameter int unsigned RES_CYCLES = 8,
  parameter logic [15:0] WP_BASE    = 16'h8000,
  parameter logic [7:0]  FILL_OP    = 8'hEA
) (
  input  logic        phi0,
  input  logic        res,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  input  logic        host_start,
  input  logic        host_halt,
  input  logic        host_reload,
  input  logic        trap_en,
  input  logic [15:0] trap_addr,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_rw,
  input  logic        cpu_sync,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_res_n,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  state,
  output logic        trap_hit,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2,
    ST_HALT       = 2'd3
  } state_e;

  localparam int unsigned HW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RES_CYCLES - 1);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   cycle_cnt_q, cycle_cnt_d;
  logic          trap_hit_q, trap_hit_d;
  logic          resume_q, resume_d;
  logic          host_ack_q, host_ack_d;
  logic [7:0]    host_rdata_q, host_rdata_d;

  logic cpu_owns;
  logic host_accept;
  logic trap_match;

  assign cpu_owns    = (state_q == ST_RESET_HOLD) || (state_q == ST_RUN);
  // The ack cycle itself never accepts, so a held request cannot be double-served.
  assign host_accept = host_req & ~cpu_owns & ~host_ack_q;
  assign trap_match  = trap_en & cpu_sync & (cpu_ab == trap_addr) & ~resume_q;

  always_comb begin
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    mem_we    = host_accept & host_we;
    cpu_din   = FILL_OP;
    if (cpu_owns) begin
      mem_addr  = cpu_ab;
      mem_wdata = cpu_dout;
      mem_we    = ~cpu_rw & (cpu_ab < WP_BASE) & (state_q == ST_RUN);
      cpu_din   = mem_rdata;
    end
  end

  always_comb begin
    host_ack_d   = host_accept;
    host_rdata_d = host_accept ? mem_rdata : host_rdata_q;
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    trap_hit_d  = trap_hit_q;
    resume_d    = 1'b0;
    cycle_cnt_d = cycle_cnt_q;
    if ((state_q == ST_RUN) && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if (host_reload) begin
      state_d    = ST_LOAD;
      trap_hit_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (host_start) begin
            state_d     = ST_RESET_HOLD;
            hold_d      = '0;
            cycle_cnt_d = '0;
          end
        end
        ST_RESET_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_RUN;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (trap_match) begin
            state_d    = ST_HALT;
            trap_hit_d = 1'b1;
          end else if (host_halt) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          // Masks the trap for one cycle so resuming at a breakpoint makes progress.
          if (host_start) begin
            state_d    = ST_RUN;
            trap_hit_d = 1'b0;
            resume_d   = 1'b1;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge phi0) begin
    if (res) begin
      state_q      <= ST_LOAD;
      hold_q       <= '0;
      cycle_cnt_q  <= '0;
      trap_hit_q   <= 1'b0;
      resume_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycle_cnt_q  <= cycle_cnt_d;
      trap_hit_q   <= trap_hit_d;
      resume_q     <= resume_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign state      = state_q;
  assign cpu_res_n  = (state_q == ST_RUN) || (state_q == ST_HALT);
  assign cpu_rdy    = (state_q != ST_HALT);
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign trap_hit   = trap_hit_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_chip_6502_run_ctrl.sv
// Bench for chip_6502_run_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_chip_6502_run_ctrl;

  logic        phi0 = 1'b0;
  logic        res, host_req, host_we, host_start, host_halt, host_reload, trap_en;
  logic [15:0] host_addr, trap_addr, cpu_ab;
  logic [7:0]  host_wdata, cpu_dout;
  logic        cpu_rw, cpu_sync;
  logic        host_ack, cpu_res_n, cpu_rdy, mem_we, trap_hit;
  logic [7:0]  host_rdata, cpu_din, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:65535];
  logic       mem_clr;

  always #5 phi0 = ~phi0;

  always @(posedge phi0) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  chip_6502_run_ctrl dut (
    .phi0(phi0), .res(res),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .host_start(host_start), .host_halt(host_halt), .host_reload(host_reload),
    .trap_en(trap_en), .trap_addr(trap_addr),
    .cpu_ab(cpu_ab), .cpu_rw(cpu_rw), .cpu_sync(cpu_sync), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_res_n(cpu_res_n), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state(state), .trap_hit(trap_hit), .cycle_cnt(cycle_cnt)
  );

  // Reference model: run state as 0..3, plus a shadow copy of memory contents.
  int          m_state, m_hold;
  logic [31:0] m_cnt;
  bit          m_trap, m_ack, m_resume;
  logic [7:0]  m_rdata;
  logic [7:0]  model_mem [0:65535];

  task automatic exp_bus(output logic we, output logic [15:0] a, output logic [7:0] wd,
                         output logic [7:0] din);
    bit cpu_own;
    cpu_own = (m_state == 1) || (m_state == 2);
    if (cpu_own) begin
      a   = cpu_ab;
      wd  = cpu_dout;
      din = model_mem[cpu_ab];
      we  = (m_state == 2) && !cpu_rw && (cpu_ab < 16'h8000);
    end else begin
      a   = host_addr;
      wd  = host_wdata;
      din = 8'hEA;
      we  = host_req && !m_ack && host_we;
    end
  endtask

  task automatic model_step(input logic we, input logic [15:0] a, input logic [7:0] wd);
    bit acc, trap, cpu_own;
    logic [7:0] rd;
    cpu_own = (m_state == 1) || (m_state == 2);
    acc = !cpu_own && host_req && !m_ack;
    rd  = model_mem[host_addr];
    if (we) model_mem[a] = wd;
    if (res) begin
      m_state = 0; m_hold = 0; m_cnt = 0; m_trap = 0; m_ack = 0; m_resume = 0; m_rdata = 0;
    end else begin
      trap = (m_state == 2) && trap_en && cpu_sync && (cpu_ab == trap_addr) && !m_resume;
      m_ack = acc;
      if (acc) m_rdata = rd;
      if (m_state == 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      m_resume = 0;
      if (host_reload) begin
        m_state = 0; m_trap = 0;
      end else if (m_state == 0 && host_start) begin
        m_state = 1; m_hold = 0; m_cnt = 0;
      end else if (m_state == 1) begin
        if (m_hold == 7) m_state = 2;
        else m_hold = m_hold + 1;
      end else if (m_state == 2 && trap) begin
        m_state = 3; m_trap = 1;
      end else if (m_state == 2 && host_halt) begin
        m_state = 3;
      end else if (m_state == 3 && host_start) begin
        m_state = 2; m_trap = 0; m_resume = 1;
      end
    end
  endtask

  task automatic tick();
    logic we;
    logic [15:0] a;
    logic [7:0] wd, din;
    exp_bus(we, a, wd, din);
    @(posedge phi0);
    model_step(we, a, wd);
    #2;
  endtask

  task automatic test_reset();
    res = 1'b1; mem_clr = 1'b1;
    tick();
    res = 1'b0; mem_clr = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (cpu_res_n !== 1'b0 || cpu_rdy !== 1'b1) begin failures++; $display("FAIL reset_cpu got res_n=%b rdy=%b exp res_n=0 rdy=1", cpu_res_n, cpu_rdy); end
    checks++; if (host_ack !== 1'b0 || host_rdata !== 8'h00) begin failures++; $display("FAIL reset_host got ack=%b rdata=%h exp ack=0 rdata=00", host_ack, host_rdata); end
    checks++; if (trap_hit !== 1'b0 || cycle_cnt !== 32'd0) begin failures++; $display("FAIL reset_status got trap=%b cnt=%0d exp 0 0", trap_hit, cycle_cnt); end
    checks++; if (cpu_din !== 8'hEA) begin failures++; $display("FAIL reset_fill got=%h exp=ea", cpu_din); end
  endtask

  task automatic test_host_rw();
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 8'hA5;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h1234) begin failures++; $display("FAIL host_wr_accept got we=%b addr=%h exp we=1 addr=1234", mem_we, mem_addr); end
    tick(); #1;
    checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL host_wr_ack got=%b exp=1", host_ack); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL host_no_accept_in_ack got we=%b exp=0", mem_we); end
    host_req = 1'b0;
    tick(); #1;
    checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL host_ack_pulse got=%b exp=0", host_ack); end
    host_req = 1'b1; host_we = 1'b0;
    tick(); #1;
    checks++; if (host_ack !== 1'b1 || host_rdata !== 8'hA5) begin failures++; $display("FAIL host_readback got ack=%b rdata=%h exp ack=1 rdata=a5", host_ack, host_rdata); end
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_start_hold();
    int low = 0;
    int guard = 0;
    cpu_rw = 1'b0; cpu_ab = 16'h0100; cpu_dout = 8'h3C; cpu_sync = 1'b0;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    while (state !== 2'd2 && guard < 40) begin
      #1;
      if (state === 2'd1) begin
        if (cpu_res_n === 1'b0) low++;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL hold_write_suppress got we=%b exp=0", mem_we); end
      end
      tick();
      guard++;
    end
    checks++; if (guard >= 40) begin failures++; $display("FAIL hold_timeout got state=%0d exp=2", state); end
    checks++; if (low !== 8 || cpu_res_n !== 1'b1) begin failures++; $display("FAIL hold_length got low=%0d res_n=%b exp low=8 res_n=1", low, cpu_res_n); end
    cpu_ab = 16'h9000; #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL wp_suppress got we=%b exp=0", mem_we); end
    cpu_ab = 16'h0100; #1;
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 8'h3C || mem_addr !== 16'h0100) begin failures++; $display("FAIL run_write got we=%b d=%h a=%h exp 1 3c 0100", mem_we, mem_wdata, mem_addr); end
    tick();
    cpu_rw = 1'b1; #1;
    checks++; if (cpu_din !== 8'h3C) begin failures++; $display("FAIL cpu_readback got=%h exp=3c", cpu_din); end
  endtask

  task automatic test_trap();
    logic [15:0] pc = 16'h1004;
    int guard = 0;
    trap_en = 1'b1; trap_addr = 16'h0FFF; cpu_rw = 1'b1;
    while (state !== 2'd3 && guard < 200) begin
      cpu_sync = 1'b1; cpu_ab = pc;
      tick(); guard++;
      cpu_sync = 1'b0;
      cpu_ab = (pc == 16'h1000) ? 16'h0FFF : 16'($urandom_range(16'h2000, 16'h20FF));
      tick(); guard++;
      if (pc == 16'h1000) begin
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL trap_needs_sync got state=%0d exp=2", state); end
      end
      pc = pc - 16'd1;
    end
    checks++; if (state !== 2'd3 || guard >= 200) begin failures++; $display("FAIL trap_halt got state=%0d exp=3", state); end
    checks++; if (trap_hit !== 1'b1 || cpu_rdy !== 1'b0 || cpu_res_n !== 1'b1) begin failures++; $display("FAIL trap_status got trap=%b rdy=%b res_n=%b exp 1 0 1", trap_hit, cpu_rdy, cpu_res_n); end
    cpu_rw = 1'b0; cpu_ab = 16'h0100; cpu_dout = 8'h77;
    repeat (5) tick();
    #1;
    checks++; if (cycle_cnt !== m_cnt || cycle_cnt == 32'd0) begin failures++; $display("FAIL cnt_frozen got=%0d exp=%0d", cycle_cnt, m_cnt); end
    checks++; if (mem_we !== 1'b0 || cpu_din !== 8'hEA) begin failures++; $display("FAIL halt_bus got we=%b din=%h exp 0 ea", mem_we, cpu_din); end
  endtask

  task automatic test_host_stall();
    int acks = 0;
    int wes = 0;
    cpu_rw = 1'b1; cpu_sync = 1'b1; cpu_ab = 16'h0FFF;
    host_start = 1'b1;
    tick();
    host_start = 1'b0; #1;
    checks++; if (state !== 2'd2 || trap_hit !== 1'b0) begin failures++; $display("FAIL resume got state=%0d trap=%b exp 2 0", state, trap_hit); end
    tick(); #1;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL resume_trap_mask got state=%0d exp=2", state); end
    cpu_sync = 1'b0; cpu_ab = 16'h9000; cpu_rw = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0100;
    repeat (50) begin
      #1;
      if (host_ack) acks++;
      if (mem_we) wes++;
      tick();
    end
    checks++; if (acks != 0 || wes != 0) begin failures++; $display("FAIL stall got acks=%0d we=%0d exp 0 0", acks, wes); end
    host_halt = 1'b1;
    tick();
    host_halt = 1'b0; #1;
    checks++; if (state !== 2'd3 || host_ack !== 1'b0) begin failures++; $display("FAIL halt_accept got state=%0d ack=%b exp 3 0", state, host_ack); end
    tick(); #1;
    checks++; if (host_ack !== 1'b1 || host_rdata !== 8'h3C) begin failures++; $display("FAIL halt_ack got ack=%b rdata=%h exp 1 3c", host_ack, host_rdata); end
    host_req = 1'b0;
    tick(); #1;
    checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL halt_ack_pulse got=%b exp=0", host_ack); end
    host_start = 1'b1;
    tick();
    host_start = 1'b0; #1;
    checks++; if (state !== 2'd2 || trap_hit !== 1'b0) begin failures++; $display("FAIL restart got state=%0d trap=%b exp 2 0", state, trap_hit); end
  endtask

  task automatic test_same_cycle();
    cpu_rw = 1'b1; cpu_sync = 1'b0;
    tick();
    cpu_sync = 1'b1; cpu_ab = trap_addr; host_halt = 1'b1;
    tick();
    host_halt = 1'b0; cpu_sync = 1'b0; #1;
    checks++; if (state !== 2'd3 || trap_hit !== 1'b1) begin failures++; $display("FAIL trap_vs_halt got state=%0d trap=%b exp 3 1", state, trap_hit); end
    host_reload = 1'b1; host_start = 1'b1;
    tick();
    host_reload = 1'b0; host_start = 1'b0; #1;
    checks++; if (state !== 2'd0 || trap_hit !== 1'b0 || cpu_res_n !== 1'b0) begin failures++; $display("FAIL reload_wins got state=%0d trap=%b res_n=%b exp 0 0 0", state, trap_hit, cpu_res_n); end
    checks++; if (cycle_cnt !== m_cnt || cycle_cnt == 32'd0) begin failures++; $display("FAIL cnt_retained got=%0d exp=%0d", cycle_cnt, m_cnt); end
  endtask

  task automatic test_res_mid();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    repeat (8) tick();
    #1;
    checks++; if (state !== 2'd2 || cycle_cnt !== 32'd0) begin failures++; $display("FAIL rerun got state=%0d cnt=%0d exp 2 0", state, cycle_cnt); end
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h4444; host_wdata = 8'h11;
    repeat (3) tick();
    res = 1'b1;
    tick();
    res = 1'b0; #1;
    checks++; if (state !== 2'd0 || cpu_res_n !== 1'b0 || cpu_rdy !== 1'b1) begin failures++; $display("FAIL midres_fsm got state=%0d res_n=%b rdy=%b exp 0 0 1", state, cpu_res_n, cpu_rdy); end
    checks++; if (host_ack !== 1'b0 || host_rdata !== 8'h00 || trap_hit !== 1'b0 || cycle_cnt !== 32'd0) begin failures++; $display("FAIL midres_regs got ack=%b rdata=%h trap=%b cnt=%0d exp 0 00 0 0", host_ack, host_rdata, trap_hit, cycle_cnt); end
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic we;
    logic [15:0] a;
    logic [7:0] wd, din;
    trap_addr = 16'h0105;
    for (int n = 0; n < 4000; n++) begin
      res         = ($urandom_range(0, 999) == 0);
      host_reload = ($urandom_range(0, 199) == 0);
      host_start  = ($urandom_range(0, 19) == 0);
      host_halt   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) trap_en = ~trap_en;
      if (host_req && host_ack) begin
        host_req = 1'b0;
      end else if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req   = 1'b1;
        host_we    = 1'($urandom);
        host_addr  = 16'h0100 + 16'($urandom_range(0, 15));
        host_wdata = 8'($urandom);
      end
      case ($urandom_range(0, 3))
        0: cpu_ab = 16'h0100 + 16'($urandom_range(0, 15));
        1: cpu_ab = 16'h8000 + 16'($urandom_range(0, 15));
        2: cpu_ab = trap_addr;
        default: cpu_ab = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
      endcase
      cpu_rw   = 1'($urandom);
      cpu_sync = 1'($urandom);
      cpu_dout = 8'($urandom);
      #1;
      exp_bus(we, a, wd, din);
      checks++;
      if (state !== 2'(m_state) || cpu_res_n !== (m_state >= 2) || cpu_rdy !== (m_state != 3) ||
          trap_hit !== m_trap || cycle_cnt !== m_cnt) begin
        failures++;
        $display("FAIL rand_fsm cyc=%0d got st=%0d resn=%b rdy=%b trap=%b cnt=%0d exp st=%0d trap=%b cnt=%0d",
                 n, state, cpu_res_n, cpu_rdy, trap_hit, cycle_cnt, m_state, m_trap, m_cnt);
      end
      checks++;
      if (host_ack !== m_ack || host_rdata !== m_rdata) begin
        failures++;
        $display("FAIL rand_host cyc=%0d got ack=%b rdata=%h exp ack=%b rdata=%h", n, host_ack, host_rdata, m_ack, m_rdata);
      end
      checks++;
      if (mem_we !== we || mem_addr !== a || cpu_din !== din || (we && mem_wdata !== wd)) begin
        failures++;
        $display("FAIL rand_bus cyc=%0d got we=%b a=%h din=%h wd=%h exp we=%b a=%h din=%h wd=%h",
                 n, mem_we, mem_addr, cpu_din, mem_wdata, we, a, din, wd);
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b0; mem_clr = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 8'h0;
    host_start = 1'b0; host_halt = 1'b0; host_reload = 1'b0;
    trap_en = 1'b0; trap_addr = 16'h0;
    cpu_ab = 16'h0; cpu_rw = 1'b1; cpu_sync = 1'b0; cpu_dout = 8'h0;
    m_state = 0; m_hold = 0; m_cnt = 0; m_trap = 0; m_ack = 0; m_resume = 0; m_rdata = 0;
    for (int i = 0; i < 65536; i++) model_mem[i] = 8'h00;
    #3;
    test_reset();
    test_host_rw();
    test_start_hold();
    test_trap();
    test_host_stall();
    test_same_cycle();
    test_res_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
